// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter
//
// Round-robin arbiter sharing one FIFO write port among REQUESTERS producers.
// Each producer offers beats with valid/ready. An accepted beat goes straight
// to the FIFO write port in the same cycle. Once the first beat of a
// multi-beat packet is accepted, the grant stays on that producer until its
// last beat is written, so packets are never interleaved.
//
// Ports
//   clock              rising-edge clock for all state
//   reset              synchronous, active-high; forces every output to 0
//   requester_valid    per-requester beat valid
//   requester_last     per-requester end-of-packet flag
//   requester_data     packed beats, requester i at [i*WIDTH +: WIDTH]
//   requester_ready    per-requester beat accepted this cycle (one-hot or 0)
//   fifo_full          FIFO full flag, stalls acceptance combinationally
//   fifo_write_enable  FIFO write strobe
//   fifo_write_data    beat of the granted requester, 0 when nothing granted
//   grant_valid        a requester is selected this cycle
//   grant_index        selected requester, 0 when grant_valid is 0
//
// State  | Meaning
// -------+---------------------------------------------------------------
// IDLE   | between packets; round-robin scan from priority_pointer
// LOCKED | mid-packet; only locked_index can be granted

module fifo_write_arbiter #(
    parameter int WIDTH           = 8,
    parameter int REQUESTERS      = 4,
    parameter int REQUESTERS_LOG2 = $clog2(REQUESTERS)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [REQUESTERS-1:0]         requester_valid,
    input  logic [REQUESTERS-1:0]         requester_last,
    input  logic [REQUESTERS*WIDTH-1:0]   requester_data,
    output logic [REQUESTERS-1:0]         requester_ready,
    input  logic                          fifo_full,
    output logic                          fifo_write_enable,
    output logic [WIDTH-1:0]              fifo_write_data,
    output logic                          grant_valid,
    output logic [REQUESTERS_LOG2-1:0]    grant_index
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t                     state;
    logic [REQUESTERS_LOG2-1:0] priority_pointer;
    logic [REQUESTERS_LOG2-1:0] locked_index;

    logic [WIDTH-1:0]           beat [REQUESTERS];
    logic                       idle_hit;
    logic [REQUESTERS_LOG2-1:0] idle_sel;
    logic [REQUESTERS_LOG2-1:0] sel;
    logic                       granted;
    logic                       accept;

    // Modulo-REQUESTERS increment; works for non-power-of-two counts too.
    function automatic logic [REQUESTERS_LOG2-1:0] wrap_inc(
        input logic [REQUESTERS_LOG2-1:0] i
    );
        if (int'(i) == REQUESTERS - 1)
            return '0;
        else
            return i + REQUESTERS_LOG2'(1);
    endfunction

    always_comb begin
        for (int i = 0; i < REQUESTERS; i++)
            beat[i] = requester_data[i*WIDTH +: WIDTH];
    end

    // Rotating scan: the first valid requester at or after the pointer wins.
    always_comb begin
        int                         j;
        logic [REQUESTERS_LOG2-1:0] cand;
        idle_hit = 1'b0;
        idle_sel = '0;
        j        = 0;
        cand     = '0;
        for (int k = 0; k < REQUESTERS; k++) begin
            j = int'(priority_pointer) + k;
            if (j >= REQUESTERS)
                j = j - REQUESTERS;
            cand = REQUESTERS_LOG2'(j);
            if (!idle_hit && requester_valid[cand]) begin
                idle_hit = 1'b1;
                idle_sel = cand;
            end
        end
    end

    always_comb begin
        sel     = (state == LOCKED) ? locked_index : idle_sel;
        granted = 1'b0;
        if (!reset)
            granted = (state == LOCKED) ? requester_valid[locked_index] : idle_hit;
        accept  = granted && !fifo_full;
    end

    assign grant_valid       = granted;
    assign grant_index       = granted ? sel : '0;
    assign fifo_write_enable = accept;
    assign fifo_write_data   = granted ? beat[sel] : '0;
    assign requester_ready   = accept ? (REQUESTERS'(1) << sel) : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= IDLE;
            priority_pointer <= '0;
            locked_index     <= '0;
        end else if (accept) begin
            case (state)
                IDLE: begin
                    if (requester_last[sel]) begin
                        priority_pointer <= wrap_inc(sel);
                    end else begin
                        state        <= LOCKED;
                        locked_index <= sel;
                    end
                end
                LOCKED: begin
                    if (requester_last[locked_index]) begin
                        state            <= IDLE;
                        priority_pointer <= wrap_inc(locked_index);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
